// File: rtl/gcm_pkg.sv
// Shared GCM definitions: GHASH controller states, block/length widths and the
// helpers that turn a valid-byte count into a bit count and a block mask.
package gcm_pkg;

    localparam int GCM_BLK_W = 128;
    localparam int GCM_LEN_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LEN   = 2'd2,
        ST_DONE  = 2'd3
    } ghash_state_t;

    // A byte count of 0 or anything above 16 means a full block.
    function automatic logic [7:0] blk_bits(input logic [4:0] bytes);
        if (bytes == 5'd0 || bytes > 5'd16)
            blk_bits = 8'd128;
        else
            blk_bits = {bytes, 3'b000};
    endfunction

    function automatic logic [0:GCM_BLK_W-1] byte_mask(input logic [4:0] bytes);
        logic [7:0] nbits;
        nbits = blk_bits(bytes);
        for (int i = 0; i < GCM_BLK_W; i++)
            byte_mask[i] = (8'(i) < nbits);
    endfunction

endpackage

// File: rtl/gfmul.sv
// Combinational GF(2^128) multiply in GCM bit order (bit 0 = coefficient of x^0).
// Shift-and-add over the 128 bits of iCtext, reducing by x^128 + x^7 + x^2 + x + 1.
module gfmul (
    input  logic [0:127] iCtext,
    input  logic [0:127] iHashkey,
    output logic [0:127] oResult
);

    localparam logic [0:127] GF_R = {8'hE1, 120'd0};

    logic [0:127] w_z;
    logic [0:127] w_v;

    always_comb begin
        w_z = '0;
        w_v = iHashkey;
        for (int i = 0; i < 128; i++) begin
            if (iCtext[i])
                w_z = w_z ^ w_v;
            // Multiply V by x: move every coefficient one position right, fold x^128 back.
            if (w_v[127])
                w_v = (w_v >> 1) ^ GF_R;
            else
                w_v = w_v >> 1;
        end
    end

    assign oResult = w_z;

endmodule

// File: rtl/ghash_core.sv
// GHASH accumulator: absorbs one masked block per clock into Y = (Y ^ X) * H,
// then folds in the len(A)||len(C) block and presents Y as the tag.
module ghash_core
    import gcm_pkg::*;
(
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [0:GCM_BLK_W-1] iHashkey,
    input  logic [0:GCM_BLK_W-1] iBlock,
    input  logic                 iBlockValid,
    input  logic                 iBlockType,
    input  logic [4:0]           iBlockBytes,
    input  logic                 iFinish,
    output logic                 oReady,
    output logic [0:GCM_BLK_W-1] oTag,
    output logic                 oTagValid
);

    ghash_state_t r_state;
    ghash_state_t w_state_next;

    logic [0:GCM_BLK_W-1] r_y;
    logic [0:GCM_BLK_W-1] r_h;
    logic [GCM_LEN_W-1:0] r_len_a;
    logic [GCM_LEN_W-1:0] r_len_c;

    logic                 w_start;
    logic                 w_accept;
    logic [0:GCM_BLK_W-1] w_len_blk;
    logic [0:GCM_BLK_W-1] w_mul_in;
    logic [0:GCM_BLK_W-1] w_mul_out;
    logic [GCM_LEN_W-1:0] w_blk_bits;

    assign w_start    = iStart & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_accept   = iBlockValid & (r_state == ST_ACCUM);
    assign w_len_blk  = {r_len_a, r_len_c};
    assign w_blk_bits = {{(GCM_LEN_W-8){1'b0}}, blk_bits(iBlockBytes)};
    assign w_mul_in   = (r_state == ST_LEN) ? (r_y ^ w_len_blk)
                                            : (r_y ^ (iBlock & byte_mask(iBlockBytes)));

    gfmul u_gfmul (
        .iCtext   (w_mul_in),
        .iHashkey (r_h),
        .oResult  (w_mul_out)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (iStart)  w_state_next = ST_ACCUM;
            ST_ACCUM: if (iFinish) w_state_next = ST_LEN;
            ST_LEN:                w_state_next = ST_DONE;
            ST_DONE:  if (iStart)  w_state_next = ST_ACCUM;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oReady    = (r_state == ST_ACCUM);
        oTagValid = (r_state == ST_DONE);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_y     <= '0;
            r_h     <= '0;
            r_len_a <= '0;
            r_len_c <= '0;
        end else if (w_start) begin
            r_y     <= '0;
            r_h     <= iHashkey;
            r_len_a <= '0;
            r_len_c <= '0;
        end else if (w_accept) begin
            r_y <= w_mul_out;
            if (iBlockType)
                r_len_c <= r_len_c + w_blk_bits;
            else
                r_len_a <= r_len_a + w_blk_bits;
        end else if (r_state == ST_LEN) begin
            r_y <= w_mul_out;
        end
    end

    // Y is zero from reset and from every accepted start, so it doubles as the tag bus.
    assign oTag = r_y;

endmodule

// File: tb/tb_ghash_core.sv
// Directed bench for ghash_core: NIST GCM vectors plus a Horner-form GF(2^128) model.
module tb_ghash_core;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iStart = 1'b0;
    logic [0:127] iHashkey = '0;
    logic [0:127] iBlock = '0;
    logic         iBlockValid = 1'b0;
    logic         iBlockType = 1'b0;
    logic [4:0]   iBlockBytes = 5'd16;
    logic         iFinish = 1'b0;
    logic         oReady;
    logic [0:127] oTag;
    logic         oTagValid;

    int checks = 0;
    int failures = 0;

    localparam logic [0:127] H1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] H2 = 128'h466923ec9ae682214f2c082badb39249;

    ghash_core dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iStart      (iStart),
        .iHashkey    (iHashkey),
        .iBlock      (iBlock),
        .iBlockValid (iBlockValid),
        .iBlockType  (iBlockType),
        .iBlockBytes (iBlockBytes),
        .iFinish     (iFinish),
        .oReady      (oReady),
        .oTag        (oTag),
        .oTagValid   (oTagValid)
    );

    always #5 iClk = ~iClk;

    // Horner evaluation: Z = sum_i X[i] * x^i * Y, highest coefficient first.
    function automatic logic [0:127] gmul(input logic [0:127] x, input logic [0:127] y);
        logic [0:127] z;
        logic         carry;
        z = '0;
        for (int i = 127; i >= 0; i--) begin
            carry = z[127];
            z = {1'b0, z[0:126]};
            if (carry) z = z ^ {8'hE1, 120'd0};
            if (x[i]) z = z ^ y;
        end
        return z;
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic start_msg(input logic [0:127] h);
        iStart = 1'b1;
        iHashkey = h;
        step();
        iStart = 1'b0;
    endtask

    task automatic finish_msg();
        iFinish = 1'b1;
        step();
        iFinish = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (oTag !== '0 || oReady !== 1'b0 || oTagValid !== 1'b0) begin failures++;
            $display("FAIL reset_outputs tag=%h ready=%b valid=%b required 0/0/0", oTag, oReady, oTagValid); end
        step();
        iRst = 1'b0;
        step();
        checks++; if (oReady !== 1'b0) begin failures++;
            $display("FAIL reset_idle ready=%b required 0", oReady); end
        $display("test_reset done");
    endtask

    task automatic test_null();
        start_msg(H1);
        checks++; if (oReady !== 1'b1 || oTagValid !== 1'b0) begin failures++;
            $display("FAIL null_accum ready=%b valid=%b required 1/0", oReady, oTagValid); end
        iFinish = 1'b1;
        step();
        iFinish = 1'b0;
        checks++; if (oReady !== 1'b0 || oTagValid !== 1'b0) begin failures++;
            $display("FAIL null_len ready=%b valid=%b required 0/0", oReady, oTagValid); end
        step();
        checks++; if (oTagValid !== 1'b1 || oTag !== '0) begin failures++;
            $display("FAIL null_tag tag=%h valid=%b required 0/1", oTag, oTagValid); end
        $display("test_null tag=%h valid=%b", oTag, oTagValid);
    endtask

    task automatic test_tc2();
        start_msg(H1);
        iBlockValid = 1'b1; iBlockType = 1'b1; iBlockBytes = 5'd16;
        iBlock = 128'h0388dace60b6a392f328c2b971b2fe78;
        step();
        iBlockValid = 1'b0;
        checks++; if (oTag !== 128'h5e2ec746917062882c85b0685353deb7) begin failures++;
            $display("FAIL tc2_x1 got=%h required 5e2ec746917062882c85b0685353deb7", oTag); end
        finish_msg();
        checks++; if (oTagValid !== 1'b1 || oTag !== 128'hf38cbb1ad69223dcc3457ae5b6b0f885) begin failures++;
            $display("FAIL tc2_tag got=%h valid=%b required f38cbb1ad69223dcc3457ae5b6b0f885/1", oTag, oTagValid); end
        checks++; if (dut.r_len_a !== 64'd0 || dut.r_len_c !== 64'h80) begin failures++;
            $display("FAIL tc2_len lenA=%h lenC=%h required 0/80", dut.r_len_a, dut.r_len_c); end
        $display("test_tc2 tag=%h", oTag);
        // Restart from DONE must drop the valid flag at the same edge.
        start_msg(H1);
        checks++; if (oTagValid !== 1'b0 || oReady !== 1'b1 || oTag !== '0) begin failures++;
            $display("FAIL restart valid=%b ready=%b tag=%h required 0/1/0", oTagValid, oReady, oTag); end
        finish_msg();
        $display("test_restart valid=%b", oTagValid);
    endtask

    task automatic test_single_mul();
        logic [0:127] blk, y1;
        blk = 128'hfeedfacedeadbeeffeedfacedeadbeef;
        y1 = gmul(blk, H2);
        start_msg(H2);
        // A start while in ACCUM must be ignored even with a different key.
        iStart = 1'b1; iHashkey = '1;
        iBlockValid = 1'b1; iBlockType = 1'b0; iBlockBytes = 5'd16; iBlock = blk;
        step();
        iStart = 1'b0; iBlockValid = 1'b0;
        checks++; if (oTag !== y1) begin failures++;
            $display("FAIL single_y got=%h required %h", oTag, y1); end
        finish_msg();
        checks++; if (oTag !== gmul(y1 ^ {64'h80, 64'h0}, H2) || dut.r_len_a !== 64'h80) begin failures++;
            $display("FAIL single_tag got=%h lenA=%h required %h/80", oTag, dut.r_len_a, gmul(y1 ^ {64'h80, 64'h0}, H2)); end
        $display("test_single_mul tag=%h", oTag);
    endtask

    task automatic test_partial();
        logic [0:127] clean, exp;
        clean = 128'h0388dace60b6a392f328c2b971000000;
        exp = gmul(gmul(clean, H1) ^ {64'h0, 64'h68}, H1);
        for (int run = 0; run < 2; run++) begin
            start_msg(H1);
            iBlockValid = 1'b1; iBlockType = 1'b1; iBlockBytes = 5'd13;
            iBlock = (run == 0) ? 128'h0388dace60b6a392f328c2b971abcdef : clean;
            step();
            iBlockValid = 1'b0;
            finish_msg();
            checks++; if (oTag !== exp || dut.r_len_c !== 64'h68) begin failures++;
                $display("FAIL partial_run%0d got=%h lenC=%h required %h/68", run, oTag, dut.r_len_c, exp); end
            $display("test_partial run=%0d tag=%h", run, oTag);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] blks [5];
        logic [4:0]   nb [5];
        logic [0:127] y;
        blks[0] = 128'h00112233445566778899aabbccddeeff;
        blks[1] = 128'hfeedfacedeadbeeffeedfacedeadbeef;
        blks[2] = 128'h0123456789abcdef0123456789abcdef;
        blks[3] = 128'h42831ec2217774244b7221b784d0d49c;
        blks[4] = 128'he3aa212f2c02a4e035c17e2329aca12e;
        nb[0] = 5'd16; nb[1] = 5'd0; nb[2] = 5'd31; nb[3] = 5'd16; nb[4] = 5'd16;
        y = '0;
        for (int k = 0; k < 5; k++) y = gmul(y ^ blks[k], H1);
        y = gmul(y ^ {64'h180, 64'h100}, H1);
        start_msg(H1);
        for (int k = 0; k < 5; k++) begin
            iBlockValid = 1'b1; iBlock = blks[k]; iBlockBytes = nb[k];
            iBlockType = (k >= 3); iFinish = (k == 4);
            checks++; if (oReady !== 1'b1) begin failures++;
                $display("FAIL b2b_ready%0d ready=%b required 1", k, oReady); end
            step();
        end
        iBlockValid = 1'b0; iFinish = 1'b0;
        checks++; if (oTagValid !== 1'b0) begin failures++;
            $display("FAIL b2b_len_valid valid=%b required 0", oTagValid); end
        step();
        checks++; if (oTagValid !== 1'b1 || oTag !== y) begin failures++;
            $display("FAIL b2b_tag got=%h valid=%b required %h/1", oTag, oTagValid, y); end
        checks++; if (dut.r_len_a !== 64'h180 || dut.r_len_c !== 64'h100) begin failures++;
            $display("FAIL b2b_len lenA=%h lenC=%h required 180/100", dut.r_len_a, dut.r_len_c); end
        $display("test_back_to_back tag=%h", oTag);
    endtask

    task automatic test_reset_mid();
        start_msg(H1);
        iBlockValid = 1'b1; iBlockType = 1'b0; iBlockBytes = 5'd16;
        iBlock = 128'h0388dace60b6a392f328c2b971b2fe78;
        step();
        iBlockValid = 1'b0;
        checks++; if (oTag === '0) begin failures++;
            $display("FAIL rstmid_pre got=%h required nonzero", oTag); end
        #1 iRst = 1'b1;
        #1;
        checks++; if (oTag !== '0 || oReady !== 1'b0 || oTagValid !== 1'b0) begin failures++;
            $display("FAIL rstmid_async tag=%h ready=%b valid=%b required 0/0/0", oTag, oReady, oTagValid); end
        checks++; if (dut.r_len_a !== 64'd0 || dut.r_h !== '0) begin failures++;
            $display("FAIL rstmid_regs lenA=%h h=%h required 0/0", dut.r_len_a, dut.r_h); end
        #1 iRst = 1'b0;
        step();
        $display("test_reset_mid tag=%h ready=%b", oTag, oReady);
        test_null();
    endtask

    initial begin
        test_reset();
        test_null();
        test_tc2();
        test_single_mul();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
